// File: rtl/pingpong_bram_pkg.sv
// Shared types and constants for the ping-pong BRAM buffer: bank ownership
// states, supported read latencies and the port packing widths.
package pingpong_bram_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    localparam int NUM_BANKS  = 2;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;
    localparam int NUM_RD_MIN = 1;
    localparam int NUM_RD_MAX = 8;

    // Bit offset of port p inside a flattened NUM_RD*w bus.
    function automatic int port_lsb(input int p, input int w);
        return p * w;
    endfunction

endpackage

// File: rtl/bram_bank_mr.sv
// One bank: single write port, NUM_RD independent read ports with registered
// outputs (1 or 2 register stages), shaped for block-RAM inference.
module bram_bank_mr #(
    parameter int DATA_WIDTH = 22,
    parameter int DEPTH      = 147708,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_RD     = 3,
    parameter int RD_LATENCY = 1
) (
    input  logic                                  clk,
    input  logic                                  we,
    input  logic [ADDR_WIDTH-1:0]                 waddr,
    input  logic [DATA_WIDTH-1:0]                 wdata,
    input  logic [NUM_RD-1:0]                     re,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]     raddr,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]     rdata
);

    logic [DATA_WIDTH-1:0]             mem [DEPTH];
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] q1;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RD; i++) begin
            if (re[i]) q1[i] <= mem[raddr[i]];
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [NUM_RD-1:0]                 re_d;
        logic [NUM_RD-1:0][DATA_WIDTH-1:0] q2;

        always_ff @(posedge clk) begin
            re_d <= re;
            for (int i = 0; i < NUM_RD; i++) begin
                if (re_d[i]) q2[i] <= q1[i];
            end
        end
        assign rdata = q2;
    end else begin : g_lat1
        assign rdata = q1;
    end

endmodule

// File: rtl/pingpong_bram.sv
// Double-buffered frame store: writer fills one bank while readers drain the
// other; frame-done pulses hand banks over without ever sharing one.
module pingpong_bram
    import pingpong_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 22,
    parameter int DEPTH      = 147708,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_RD     = 3,
    parameter int RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         wr_frame_done,
    output logic                         wr_ready,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    input  logic                         rd_frame_done,
    output logic                         rd_ready,
    output logic                         wr_bank,
    output logic                         rd_bank,
    output logic                         err_wr_drop,
    output logic                         err_rd_drop,
    output logic                         err_addr
);

    if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_lat
        $error("pingpong_bram: RD_LATENCY must be 1 or 2");
    end
    if (NUM_RD < NUM_RD_MIN || NUM_RD > NUM_RD_MAX) begin : g_bad_nrd
        $error("pingpong_bram: NUM_RD must be 1..8");
    end

    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

    bank_state_t [NUM_BANKS-1:0] st_q, st_n;
    logic wb_q, wb_n, rb_q, rb_n;
    logic wr_rdy_q, wr_rdy_n, rd_rdy_q, rd_rdy_n;

    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] raddr;
    logic [NUM_RD-1:0]                 rd_in_rng, rd_acc;
    logic                              wr_in_rng, wr_acc;

    logic [NUM_BANKS-1:0][NUM_RD-1:0][DATA_WIDTH-1:0] bank_rdata;
    logic [RD_LATENCY-1:0][NUM_RD-1:0]                vld_pipe, bsel_pipe;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]                rd_data_w, hold_q;

    assign raddr     = rd_addr;
    assign wr_in_rng = {1'b0, wr_addr} < DEPTH_W;
    assign wr_acc    = wr_en && wr_rdy_q && wr_in_rng;

    always_comb begin
        rd_in_rng = '0;
        for (int i = 0; i < NUM_RD; i++) rd_in_rng[i] = {1'b0, raddr[i]} < DEPTH_W;
    end
    assign rd_acc = rd_en & rd_in_rng & {NUM_RD{rd_rdy_q}};

    // Release both banks first, then let the reader grab a FULL bank and the
    // writer an EMPTY one, so a same-cycle swap settles in a single step.
    always_comb begin
        st_n     = st_q;
        wb_n     = wb_q;
        rb_n     = rb_q;
        wr_rdy_n = wr_rdy_q;
        rd_rdy_n = rd_rdy_q;
        if (rd_frame_done && rd_rdy_q) begin
            st_n[rb_q] = BANK_EMPTY;
            rd_rdy_n   = 1'b0;
        end
        if (wr_frame_done && wr_rdy_q) begin
            st_n[wb_q] = BANK_FULL;
            wr_rdy_n   = 1'b0;
        end
        if (!rd_rdy_n) begin
            if (st_n[~rb_q] == BANK_FULL) begin
                st_n[~rb_q] = BANK_READING;
                rb_n        = ~rb_q;
                rd_rdy_n    = 1'b1;
            end else if (st_n[rb_q] == BANK_FULL) begin
                st_n[rb_q]  = BANK_READING;
                rd_rdy_n    = 1'b1;
            end
        end
        if (!wr_rdy_n) begin
            if (st_n[~wb_q] == BANK_EMPTY) begin
                st_n[~wb_q] = BANK_FILLING;
                wb_n        = ~wb_q;
                wr_rdy_n    = 1'b1;
            end else if (st_n[wb_q] == BANK_EMPTY) begin
                st_n[wb_q]  = BANK_FILLING;
                wr_rdy_n    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q[0]     <= BANK_FILLING;
            st_q[1]     <= BANK_EMPTY;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wr_rdy_q    <= 1'b1;
            rd_rdy_q    <= 1'b0;
            err_wr_drop <= 1'b0;
            err_rd_drop <= 1'b0;
            err_addr    <= 1'b0;
        end else begin
            st_q     <= st_n;
            wb_q     <= wb_n;
            rb_q     <= rb_n;
            wr_rdy_q <= wr_rdy_n;
            rd_rdy_q <= rd_rdy_n;
            if (wr_en && !wr_rdy_q)                        err_wr_drop <= 1'b1;
            if (|rd_en && !rd_rdy_q)                       err_rd_drop <= 1'b1;
            if ((wr_en && !wr_in_rng) || |(rd_en & ~rd_in_rng)) err_addr <= 1'b1;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bram_bank_mr #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_RD     (NUM_RD),
            .RD_LATENCY (RD_LATENCY)
        ) u_bank (
            .clk   (clk),
            .we    (wr_acc && (wb_q == 1'(b))),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (rd_acc & {NUM_RD{rb_q == 1'(b)}}),
            .raddr (raddr),
            .rdata (bank_rdata[b])
        );
    end

    // Bank select travels with the valid bit so the mux picks the bank that
    // was read, even if rd_bank has swapped since.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            bsel_pipe <= '0;
            hold_q    <= '0;
        end else begin
            vld_pipe[0]  <= rd_acc;
            bsel_pipe[0] <= {NUM_RD{rb_q}};
            for (int s = 1; s < RD_LATENCY; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                bsel_pipe[s] <= bsel_pipe[s-1];
            end
            hold_q <= rd_data_w;
        end
    end

    always_comb begin
        rd_data_w = hold_q;
        for (int i = 0; i < NUM_RD; i++) begin
            if (vld_pipe[RD_LATENCY-1][i])
                rd_data_w[i] = bank_rdata[bsel_pipe[RD_LATENCY-1][i]][i];
        end
    end

    assign rd_data  = rd_data_w;
    assign rd_valid = vld_pipe[RD_LATENCY-1];
    assign wr_ready = wr_rdy_q;
    assign rd_ready = rd_rdy_q;
    assign wr_bank  = wb_q;
    assign rd_bank  = rb_q;

endmodule
